// File: rtl/fp_div_arbiter_pkg.sv
// rtl/fp_div_arbiter_pkg.sv - shared FSM state type and divider status bit indices
package fp_div_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int STAT_ZERO        = 0;
  localparam int STAT_INF         = 1;
  localparam int STAT_INVALID     = 2;
  localparam int STAT_TINY        = 3;
  localparam int STAT_HUGE        = 4;
  localparam int STAT_INEXACT     = 5;
  localparam int STAT_DIV_BY_ZERO = 7;

endpackage

// File: rtl/fp_div_arbiter_dw_fp_div.sv
// rtl/fp_div_arbiter_dw_fp_div.sv - combinational IEEE-style divider, DW_fp_div-compatible ports
module DW_fp_div
  import fp_div_arbiter_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int faithful_round  = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int SW = sig_width;
  localparam int EW = exp_width;
  localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW-1)) - 1);
  localparam logic [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);
  localparam logic [SW-1:0] NAN_FRAC = (ieee_compliance != 0) ?
      {1'b1, {(SW-1){1'b0}}} : {{(SW-1){1'b0}}, 1'b1};

  logic [EW-1:0]   w_ea, w_eb;
  logic [SW-1:0]   w_fa, w_fb, w_frac;
  logic            w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan;
  logic [2*SW+2:0] w_num, w_den, w_rem;
  logic [SW+2:0]   w_q;
  logic [SW:0]     w_mant;
  logic            w_hi, w_sticky, w_guard, w_inc, w_carry, w_ovf_inf, w_ovf, w_unf;
  logic [EW+1:0]   w_exp_pre, w_exp;

  assign w_ea     = a[SW +: EW];
  assign w_eb     = b[SW +: EW];
  assign w_fa     = a[SW-1:0];
  assign w_fb     = b[SW-1:0];
  assign w_sign   = a[SW+EW] ^ b[SW+EW];
  // Subnormal inputs are flushed to zero.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_nan    = ((&w_ea) && (w_fa != '0)) || ((&w_eb) && (w_fb != '0)) ||
                    (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);

  assign w_num    = {1'b1, w_fa, {(SW+2){1'b0}}};
  assign w_den    = {{(SW+2){1'b0}}, 1'b1, w_fb};
  assign w_q      = (SW+3)'(w_num / w_den);
  assign w_rem    = w_num % w_den;
  assign w_hi     = w_q[SW+2];
  // Hidden bit is implied; w_mant holds fraction plus one guard bit.
  assign w_mant   = w_hi ? w_q[SW+1:1] : w_q[SW:0];
  assign w_sticky = (w_rem != '0) || (w_hi && w_q[0]);
  assign w_guard  = w_mant[0];
  assign w_exp_pre = {2'b00, w_ea} - {2'b00, w_eb} + BIAS - {{(EW+1){1'b0}}, ~w_hi};
  assign {w_carry, w_frac} = {1'b0, w_mant[SW:1]} + {{SW{1'b0}}, w_inc};
  assign w_exp    = w_exp_pre + {{(EW+1){1'b0}}, w_carry};
  assign w_ovf    = !w_exp[EW+1] && (w_exp >= EMAX);
  assign w_unf    = w_exp[EW+1] || (w_exp == '0);

  always_comb begin
    w_inc     = 1'b0;
    w_ovf_inf = 1'b1;
    case (rnd)
      3'd0: w_inc = w_guard & (w_sticky | w_mant[1]);
      3'd1: begin w_inc = 1'b0; w_ovf_inf = 1'b0; end
      3'd2: begin w_inc = ~w_sign & (w_guard | w_sticky); w_ovf_inf = ~w_sign; end
      3'd3: begin w_inc = w_sign & (w_guard | w_sticky); w_ovf_inf = w_sign; end
      3'd4: w_inc = w_guard;
      3'd5: w_inc = w_guard | w_sticky;
      default: w_inc = 1'b0;
    endcase
    if (faithful_round != 0) w_inc = 1'b0;
  end

  always_comb begin
    z = {w_sign, w_exp[EW-1:0], w_frac};
    status = '0;
    status[STAT_INEXACT] = w_guard | w_sticky;
    if (w_nan) begin
      z = {1'b0, {EW{1'b1}}, NAN_FRAC};
      status = '0;
      status[STAT_INVALID] = 1'b1;
    end else if (w_a_inf || w_b_zero) begin
      z = {w_sign, {EW{1'b1}}, {SW{1'b0}}};
      status = '0;
      status[STAT_INF] = 1'b1;
      status[STAT_DIV_BY_ZERO] = !w_a_inf;
    end else if (w_a_zero || w_b_inf) begin
      z = {w_sign, {(EW+SW){1'b0}}};
      status = '0;
      status[STAT_ZERO] = 1'b1;
    end else if (w_ovf) begin
      status[STAT_HUGE] = 1'b1;
      status[STAT_INEXACT] = 1'b1;
      status[STAT_INF] = w_ovf_inf;
      z = w_ovf_inf ? {w_sign, {EW{1'b1}}, {SW{1'b0}}}
                    : {w_sign, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
    end else if (w_unf) begin
      z = {w_sign, {(EW+SW){1'b0}}};
      status[STAT_ZERO] = 1'b1;
      status[STAT_TINY] = 1'b1;
      status[STAT_INEXACT] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// rtl/fp_div_arbiter_rr_arbiter.sv - round-robin selector, first request at or above ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - round-robin sharing of one combinational divider among NREQ requesters
module fp_div_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int NREQ            = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ*(sig_width+exp_width+1)-1:0]  req_a,
  input  logic [NREQ*(sig_width+exp_width+1)-1:0]  req_b,
  input  logic [2:0]                               cfg_rnd,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]                  rsp_id,
  output logic [sig_width+exp_width:0]             rsp_z,
  output logic [7:0]                               rsp_status
);

  localparam int W  = sig_width + exp_width + 1;
  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [W-1:0]    r_a, r_b;
  logic [2:0]      r_rnd;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [W-1:0]    w_z;
  logic [7:0]      w_status;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  DW_fp_div #(
    .sig_width       (sig_width),
    .exp_width       (exp_width),
    .ieee_compliance (ieee_compliance),
    .faithful_round  (0)
  ) u_div (
    .a      (r_a),
    .b      (r_b),
    .rnd    (r_rnd),
    .z      (w_z),
    .status (w_status)
  );

  // The grant is visible in the same IDLE cycle it is taken.
  assign req_ready = (r_state == ST_IDLE && !reset) ? w_grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rnd      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_z      <= '0;
      rsp_status <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a     <= req_a[w_idx*W +: W];
            r_b     <= req_b[w_idx*W +: W];
            r_rnd   <= cfg_rnd;
            rsp_id  <= w_idx;
            r_ptr   <= (w_idx == IW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_z      <= w_z;
          rsp_status <= w_status;
          rsp_valid  <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb/tb_fp_div_arbiter.sv - directed self-checking bench for fp_div_arbiter
module tb_fp_div_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [2:0]   cfg_rnd;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_z;
  logic [7:0]   rsp_status;

  int checks = 0;
  int fails  = 0;

  fp_div_arbiter #(.sig_width(23), .exp_width(8), .ieee_compliance(0), .NREQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .cfg_rnd    (cfg_rnd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status)
  );

  always #5 clk = ~clk;

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic grant_cycle(input logic [3:0] mask, output logic [3:0] rdy);
    req_valid = mask;
    #1;
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 4'h0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; cfg_rnd = 3'd0;
    req_a = '0; req_b = '0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_z !== 32'h0) begin fails++; $display("FAIL reset_rsp_z: got %h want 00000000", rsp_z); end
    checks++; if (rsp_status !== 8'h0) begin fails++; $display("FAIL reset_rsp_status: got %h want 00", rsp_status); end
    req_valid = 4'h0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    int lat;
    set_slot(0, 32'h40C00000, 32'h40000000);
    cfg_rnd = 3'd0;
    grant_cycle(4'b0001, rdy);
    req_a = '1; req_b = '1; cfg_rnd = 3'd3;
    checks++; if (rdy !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", rdy); end
    checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL single_calc_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_calc_valid: got %b want 0", rsp_valid); end
    wait_rsp(lat);
    checks++; if (lat !== 2) begin fails++; $display("FAIL single_latency: got %0d want 2", lat); end
    checks++; if (rsp_z !== 32'h40400000) begin fails++; $display("FAIL single_z: got %h want 40400000", rsp_z); end
    checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_status !== 8'h00) begin fails++; $display("FAIL single_status: got %h want 00", rsp_status); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_idle_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_div_zero();
    logic [3:0] rdy;
    int lat;
    set_slot(2, 32'h3F800000, 32'h00000000);
    cfg_rnd = 3'd0;
    grant_cycle(4'b0100, rdy);
    checks++; if (rdy !== 4'b0100) begin fails++; $display("FAIL dz_grant: got %b want 0100", rdy); end
    wait_rsp(lat);
    checks++; if (lat !== 2) begin fails++; $display("FAIL dz_latency: got %0d want 2", lat); end
    checks++; if (rsp_z !== 32'h7F800000) begin fails++; $display("FAIL dz_z: got %h want 7f800000", rsp_z); end
    checks++; if (rsp_status[7] !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b want 1", rsp_status[7]); end
    checks++; if (rsp_status[1] !== 1'b1) begin fails++; $display("FAIL dz_inf_flag: got %b want 1", rsp_status[1]); end
    checks++; if (rsp_status !== 8'h82) begin fails++; $display("FAIL dz_status: got %h want 82", rsp_status); end
    checks++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL dz_id: got %0d want 2", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [3:0] rdy;
    int lat;
    set_slot(0, 32'h3F800000, 32'h40400000);
    set_slot(2, 32'h40C00000, 32'h40000000);
    cfg_rnd = 3'd0;
    grant_cycle(4'b0101, rdy);
    checks++; if (rdy !== 4'b0001) begin fails++; $display("FAIL wrap_grant: got %b want 0001", rdy); end
    wait_rsp(lat);
    checks++; if (rsp_z !== 32'h3EAAAAAB) begin fails++; $display("FAIL wrap_z_rne: got %h want 3eaaaaab", rsp_z); end
    checks++; if (rsp_status !== 8'h20) begin fails++; $display("FAIL wrap_status: got %h want 20", rsp_status); end
    checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL wrap_id: got %0d want 0", rsp_id); end
    @(posedge clk); #1;
    set_slot(1, 32'hBF800000, 32'h40400000);
    cfg_rnd = 3'd2;
    grant_cycle(4'b0011, rdy);
    checks++; if (rdy !== 4'b0010) begin fails++; $display("FAIL wrap_ptr1_grant: got %b want 0010", rdy); end
    wait_rsp(lat);
    checks++; if (rsp_z !== 32'hBEAAAAAA) begin fails++; $display("FAIL wrap_z_rup_neg: got %h want beaaaaaa", rsp_z); end
    checks++; if (rsp_id !== 2'd1) begin fails++; $display("FAIL wrap_ptr1_id: got %0d want 1", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [31:0] exp_z [4];
    exp_z[0] = 32'h3F000000; exp_z[1] = 32'h3F800000;
    exp_z[2] = 32'h40000000; exp_z[3] = 32'h40800000;
    reset = 1'b1; #1; reset = 1'b0;
    @(posedge clk); #1;
    set_slot(0, 32'h3F800000, 32'h40000000);
    set_slot(1, 32'h40000000, 32'h40000000);
    set_slot(2, 32'h40800000, 32'h40000000);
    set_slot(3, 32'h41000000, 32'h40000000);
    cfg_rnd = 3'd0; rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % 4))) begin fails++; $display("FAIL fair_grant_%0d: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      @(posedge clk); #1;
      checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL fair_calc_ready_%0d: got %b want 0000", k, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin fails++; $display("FAIL fair_id_%0d: got valid %b id %0d want valid 1 id %0d", k, rsp_valid, rsp_id, k % 4); end
      checks++; if (rsp_z !== exp_z[k % 4]) begin fails++; $display("FAIL fair_z_%0d: got %h want %h", k, rsp_z, exp_z[k % 4]); end
      @(posedge clk);
    end
    #1;
    req_valid = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_slot(1, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_%0d: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_z !== 32'h3F800000 || rsp_id !== 2'd1) begin fails++; $display("FAIL bp_hold_%0d: got z %h id %0d want z 3f800000 id 1", i, rsp_z, rsp_id); end
      checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0000", i, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_idle_grant: got %b want 0100", req_ready); end
    req_valid = 4'h0;
    #1;
    checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL idle_no_req: got %b want 0000", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    logic [3:0] rdy;
    logic seen;
    int lat;
    set_slot(3, 32'h40C00000, 32'h40000000);
    rsp_ready = 1'b1; cfg_rnd = 3'd0;
    grant_cycle(4'b1000, rdy);
    checks++; if (rdy !== 4'b1000) begin fails++; $display("FAIL rst_pre_grant: got %b want 1000", rdy); end
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin fails++; $display("FAIL rst_mid_valid_id: got valid %b id %0d want 0 0", rsp_valid, rsp_id); end
    checks++; if (rsp_z !== 32'h0 || rsp_status !== 8'h0) begin fails++; $display("FAIL rst_mid_z_status: got z %h status %h want 0 0", rsp_z, rsp_status); end
    checks++; if (req_ready !== 4'h0) begin fails++; $display("FAIL rst_mid_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_pulse: got %b want 0", seen); end
    set_slot(0, 32'h40C00000, 32'h40000000);
    grant_cycle(4'b1111, rdy);
    checks++; if (rdy !== 4'b0001) begin fails++; $display("FAIL rst_post_grant: got %b want 0001", rdy); end
    wait_rsp(lat);
    checks++; if (lat !== 2 || rsp_z !== 32'h40400000 || rsp_id !== 2'd0) begin fails++; $display("FAIL rst_post_rsp: got lat %0d z %h id %0d want 2 40400000 0", lat, rsp_z, rsp_id); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    cfg_rnd = 3'd0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_div_zero();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 The block SHALL have parameter sig_width, default 23, significand width passed to the divider.
REQ-002 The block SHALL have parameter exp_width, default 8, exponent width passed to the divider.
REQ-003 The block SHALL have parameter ieee_compliance, default 0, passed to the divider.
REQ-004 The block SHALL have parameter NREQ, default 4, number of requesters (2..8); W = sig_width+exp_width+1.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all flops rise on posedge clk.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, NREQ, per-requester request.
REQ-008 The block SHALL have port req_ready, output, NREQ, one-hot grant/accept.
REQ-009 The block SHALL have port req_a, input, NREQ*W, packed dividends, slot i at [i*W +: W].
REQ-010 The block SHALL have port req_b, input, NREQ*W, packed divisors, same packing.
REQ-011 The block SHALL have port cfg_rnd, input, 3, rounding mode, sampled at grant.
REQ-012 The block SHALL have port rsp_valid, output, 1, result available.
REQ-013 The block SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-014 The block SHALL have port rsp_id, output, clog2(NREQ), requester index of the result.
REQ-015 The block SHALL have port rsp_z, output, W, quotient.
REQ-016 The block SHALL have port rsp_status, output, 8, divider status flags unmodified.

Function
REQ-017 The block SHALL share one combinational DW_fp_div (faithful_round 0, en_ubr_flag 0) among NREQ requesters, one operation in flight.
REQ-018 The FSM SHALL have states IDLE, CALC, RESP.
REQ-019 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one granted index g in the same cycle (combinational from req_valid and pointer), latch a, b, cfg_rnd and g, and go to CALC.
REQ-020 In IDLE with no req_valid, the block SHALL hold req_ready all-zero and stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: g is the first asserted index searching upward from pointer ptr with wrap from NREQ-1 to 0; on grant ptr SHALL become (g+1) mod NREQ.
REQ-022 req_ready SHALL be all-zero in CALC and RESP.
REQ-023 In CALC the block SHALL register divider z and status into rsp_z/rsp_status and go to RESP.
REQ-024 In RESP rsp_valid SHALL be 1 and rsp_z, rsp_status, rsp_id SHALL be stable until the cycle rsp_ready is 1, after which the state SHALL return to IDLE.
REQ-025 Minimum latency SHALL be 2 cycles from grant edge to rsp_valid high; best-case throughput one operation per 3 cycles.
REQ-026 A requester dropping req_valid while not granted SHALL lose nothing; a grant SHALL be issued only to a requester whose req_valid is high that cycle.
REQ-027 Changes on req_* or cfg_rnd after grant SHALL NOT affect the in-flight result.

Reset
REQ-028 Asserting reset at any time, including mid-operation, SHALL immediately force state IDLE, ptr 0, rsp_valid 0, req_ready 0, rsp_id 0, rsp_z 0, rsp_status 0; the in-flight operation is discarded.
REQ-029 After reset release the first grant SHALL follow REQ-019 on the next rising edge.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (2-bit) and the status bit index constants (bit0 zero, bit1 infinity, bit2 invalid, bit5 inexact, bit7 divide-by-zero).
REQ-031 The round-robin selector SHALL be a sub-module named rr_arbiter (inputs req, ptr; output one-hot grant, index).

Verification
REQ-032 Single op: reset, req_valid=0001, a=0x40C00000, b=0x40000000, rnd=0 -> req_ready=0001 that cycle, rsp_valid 2 cycles later, rsp_z=0x40400000, rsp_id=0, status=0x00.
REQ-033 Divide by zero: a=0x3F800000, b=0x00000000 -> rsp_z=0x7F800000, status[7]=1, status[1]=1.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id sequence matches.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_z stable, req_ready stays 0000; rsp_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-CALC: assert reset in CALC -> all outputs 0, state IDLE, no rsp_valid pulse; next request granted from index 0.
REQ-037 Wrap: ptr=3 after granting 2, req_valid=0101 -> grant index 0, ptr becomes 1.
